// File: rtl/sr_lut_accum_if.sv
// Beat-in / pixel-out handshake bundle for the SR-LUT accumulator stage.
// The slave view belongs to the accumulator, the master view to the surrounding fabric.
interface sr_lut_accum_if #(
  parameter int UPS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic [UPS*UPS*8-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [UPS*UPS*8-1:0]   out_data;
  logic                   seq_err;

  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  in_ready, out_valid, out_data, seq_err
  );

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output in_ready, out_valid, out_data, seq_err
  );
endinterface

// File: rtl/sr_lut_accum.sv
// Accumulates NUM_ACC signed residual beats per pixel, then rounds, biases and
// clamps each lane to an unsigned 8-bit sub-pixel held in a one-pixel output buffer.
module sr_lut_accum #(
  parameter int UPS     = 4,
  parameter int NUM_ACC = 4,
  parameter int DIV     = 4,
  parameter int BIAS    = 0,
  parameter int ACC_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_lut_accum_if.slave bus
);
  localparam int  LANES    = UPS * UPS;
  localparam int  DW       = LANES * 8;
  localparam int  CW       = $clog2(NUM_ACC + 1);
  localparam int  SH       = $clog2(DIV);
  localparam bit  DIV_POW2 = (DIV & (DIV - 1)) == 0;

  typedef logic signed [ACC_W+1:0] wide_t;
  typedef enum logic {ACCUM, OUT} state_t;

  function automatic logic signed [ACC_W-1:0] sext8(input logic [7:0] b);
    return $signed({{(ACC_W-8){b[7]}}, b});
  endfunction

  // Round half away from zero on the magnitude, restore sign, then bias and clamp.
  function automatic logic [7:0] round_sat(input logic signed [ACC_W-1:0] s);
    wide_t mag;
    wide_t q;
    wide_t r;
    mag = s[ACC_W-1] ? -wide_t'(s) : wide_t'(s);
    if (DIV_POW2) q = (mag + wide_t'(DIV / 2)) >>> SH;
    else          q = (mag + wide_t'(DIV / 2)) / wide_t'(DIV);
    if (s[ACC_W-1]) q = -q;
    r = q + wide_t'(BIAS);
    if (r[ACC_W+1])            return 8'd0;
    else if (r > wide_t'(255)) return 8'hff;
    else                       return r[7:0];
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_nx;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic signed [ACC_W-1:0]  sum_w [LANES];
  logic [DW-1:0]            lanes_w;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     seq_err_q, seq_err_d;
  logic                     restart_w;

  // A first-marker or an empty counter starts a fresh sum, dropping any partial one.
  always_comb begin
    restart_w = (cnt_q == '0) || bus.in_first;
    lanes_w   = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_w[i] = restart_w ? sext8(bus.in_data[8*i +: 8])
                           : acc_q[i] + sext8(bus.in_data[8*i +: 8]);
      lanes_w[8*i +: 8] = round_sat(sum_w[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_nx      = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    seq_err_d   = seq_err_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d = sum_w;
          if (bus.in_first && (cnt_q != '0)) seq_err_d = 1'b1;
          cnt_nx = restart_w ? CW'(1) : cnt_q + CW'(1);
          if (cnt_nx == CW'(NUM_ACC)) begin
            out_data_d  = lanes_w;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = OUT;
          end else begin
            cnt_d = cnt_nx;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_sr_lut_accum.sv
// Drives three accumulator instances (different DIV/BIAS) with one shared stream
// and scores every output pixel against a beat-list reference model.
module tb_sr_lut_accum;
  localparam int UPS     = 4;
  localparam int LANES   = UPS * UPS;
  localparam int DW      = LANES * 8;
  localparam int NUM_ACC = 4;
  localparam int NI      = 3;

  function automatic int div_of(int k);
    return (k == 2) ? 3 : 4;
  endfunction
  function automatic int bias_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 128 : 200;
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_first, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready_w  [NI];
  logic          out_valid_w [NI];
  logic          seq_err_w   [NI];
  logic [DW-1:0] out_data_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    sr_lut_accum_if #(.UPS(UPS)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_first  = in_first;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;
    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign out_data_w[g]  = bus.out_data;
    assign seq_err_w[g]   = bus.seq_err;
    sr_lut_accum #(
      .UPS(UPS), .NUM_ACC(NUM_ACC), .DIV(div_of(g)), .BIAS(bias_of(g)), .ACC_W(16)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of beats of the current pixel, plain integer arithmetic.
  typedef int beat_t [LANES];
  beat_t                pix_q [$];
  logic [NI*DW-1:0]     exp_q [$];
  bit                   pending = 1'b0;
  bit                   exp_seq = 1'b0;

  function automatic int ref_lane(int s, int div, int bias);
    int q, r;
    q = (s < 0) ? -s : s;
    q = (q + div / 2) / div;
    if (s < 0) q = -q;
    r = q + bias;
    return (r < 0) ? 0 : (r > 255) ? 255 : r;
  endfunction

  task automatic model_beat(bit first, logic [DW-1:0] d);
    beat_t            b;
    logic [NI*DW-1:0] e;
    int               s;
    for (int i = 0; i < LANES; i++) b[i] = int'($signed(d[8*i +: 8]));
    if (first && pix_q.size() != 0) exp_seq = 1'b1;
    if (first) pix_q.delete();
    pix_q.push_back(b);
    if (pix_q.size() == NUM_ACC) begin
      e = '0;
      for (int k = 0; k < NI; k++)
        for (int i = 0; i < LANES; i++) begin
          s = 0;
          foreach (pix_q[j]) s += pix_q[j][i];
          e[k*DW + 8*i +: 8] = 8'(ref_lane(s, div_of(k), bias_of(k)));
        end
      exp_q.push_back(e);
      pix_q.delete();
      pending = 1'b1;
    end
  endtask

  // Monitor: sample between edges, compare handshake state and any presented pixel.
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_q.delete();
      exp_q.delete();
      pending = 1'b0;
      exp_seq = 1'b0;
      for (int g = 0; g < NI; g++) begin
        check($sformatf("rst_out_valid[%0d]", g), DW'(out_valid_w[g]), '0);
        check($sformatf("rst_out_data[%0d]", g), out_data_w[g], '0);
        check($sformatf("rst_seq_err[%0d]", g), DW'(seq_err_w[g]), '0);
        check($sformatf("rst_in_ready[%0d]", g), DW'(in_ready_w[g]), DW'(1));
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        check($sformatf("in_ready[%0d]", g), DW'(in_ready_w[g]), DW'(!pending));
        check($sformatf("out_valid[%0d]", g), DW'(out_valid_w[g]), DW'(pending));
        check($sformatf("seq_err[%0d]", g), DW'(seq_err_w[g]), DW'(exp_seq));
        if (pending) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_data[%0d]: got %h expected none queued", g, out_data_w[g]);
          end else begin
            check($sformatf("out_data[%0d]", g), out_data_w[g], exp_q[0][g*DW +: DW]);
          end
        end
      end
      if (pending && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        pending = 1'b0;
      end else if (!pending && in_valid) begin
        model_beat(in_first, in_data);
      end
    end
  end

  bit rand_rdy = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [DW-1:0] mk(int v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(bit f, logic [DW-1:0] d);
    bit acc;
    int w;
    in_valid = 1'b1; in_first = f; in_data = d;
    w = 0;
    do begin
      @(negedge clk); acc = in_ready_w[0];
      @(posedge clk); #1; w++;
    end while (!acc && w < 100);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept: got no accept in %0d cycles expected accept", w);
    end
    in_valid = 1'b0; in_first = 1'($urandom_range(0, 1)); in_data = rnd_data();
  endtask

  task automatic send_pixel(logic [DW-1:0] d);
    send_beat(1'b1, d);
    repeat (NUM_ACC - 1) send_beat(1'b0, d);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      check($sformatf("async_rst_out_valid[%0d]", g), DW'(out_valid_w[g]), '0);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int            l0 [4] = '{-3, -3, -3, -2};
    int            l1 [4] = '{3, 3, 2, 2};
    logic [DW-1:0] v;
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;

    send_pixel(mk(10));
    idle(3);

    for (int b = 0; b < 4; b++) begin
      v = '0;
      v[7:0]  = 8'(l0[b]);
      v[15:8] = 8'(l1[b]);
      send_beat(b == 0, v);
    end
    idle(3);

    send_pixel(mk(127));
    send_pixel(mk(-128));
    idle(2);

    out_ready = 1'b0;
    send_pixel(mk(50));
    in_valid = 1'b1; in_first = 1'b1; in_data = mk(77);
    idle(5);
    out_ready = 1'b1;
    send_beat(1'b1, mk(5));
    repeat (3) send_beat(1'b0, mk(9));
    idle(3);

    send_beat(1'b1, mk(7));
    send_beat(1'b0, mk(7));
    send_beat(1'b1, mk(5));
    repeat (3) send_beat(1'b0, mk(5));
    idle(3);

    send_beat(1'b1, mk(3));
    send_beat(1'b0, mk(3));
    pulse_reset();
    send_pixel(mk(1));
    idle(3);

    out_ready = 1'b0;
    send_pixel(mk(20));
    idle(1);
    pulse_reset();
    out_ready = 1'b1;
    send_pixel(mk(1));
    idle(3);

    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      for (int b = 0; b < NUM_ACC; b++) begin
        send_beat((b == 0) || ($urandom_range(0, 9) == 0), rnd_data());
        idle($urandom_range(0, 1));
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(10);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pixels outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
